lutnn_frame_ctrl: RTL
=====================

LUTNN_FRAME_CTRL -- requirements
Module: lutnn_frame_ctrl

Interface
REQ-001 SHALL have parameter IN_BITS, default 400; network input vector width; N_IN_BYTES = ceil(IN_BITS/8).
REQ-002 SHALL have parameter OUT_BITS, default 4; network output width; N_OUT_BYTES = ceil(OUT_BITS/8).
REQ-003 SHALL have parameter NET_LATENCY, default 0; cycles from net_start until net_out is valid; 0 means combinational.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 120000; maximum idle cycles between payload bytes (10 ms at 12 MHz).
REQ-005 SHALL have parameter SYNC_BYTE, default 8'hA5; frame header value.
REQ-006 SHALL have port clk, input, 1; single clock domain.
REQ-007 SHALL have port rst_n, input, 1; reset, asynchronous, active-low.
REQ-008 SHALL have ports s_tdata, s_tvalid, s_tready: input 8, input 1, output 1; byte stream from uart_rx.
REQ-009 SHALL have ports m_tdata, m_tvalid, m_tready: output 8, output 1, input 1; byte stream to uart_tx.
REQ-010 SHALL have port net_in, output, IN_BITS; registered network input vector.
REQ-011 SHALL have port net_start, output, 1; one-cycle pulse that starts inference.
REQ-012 SHALL have port net_out, input, OUT_BITS; network result.
REQ-013 SHALL have port err_cnt, output, 8; count of aborted frames, saturating.
REQ-014 SHALL have port busy, output, 1; high in every state except HUNT.

Function
REQ-015 SHALL implement the states HUNT, RECV, WAIT and SEND.
REQ-016 HUNT: s_tready=1; each accepted byte other than SYNC_BYTE SHALL be discarded; an accepted SYNC_BYTE SHALL go to RECV, clear the byte counter and clear the idle counter.
REQ-017 RECV: s_tready=1; each accepted byte SHALL shift into the LSB end of the shift register, so the first byte lands in the MSB end and the padding bits sit in the top of the first byte. net_in SHALL equal the low IN_BITS of that register.
REQ-018 RECV: when byte N_IN_BYTES-1 is accepted, the FSM SHALL go to WAIT and net_start SHALL pulse in the following cycle.
REQ-019 RECV: the idle counter SHALL increment on each cycle with no handshake and clear on each handshake; at TIMEOUT_CYC the FSM SHALL increment err_cnt (saturating at 255), discard the partial frame and return to HUNT.
REQ-020 A SYNC_BYTE received inside a payload SHALL be treated as data; there is no resync mid-frame.
REQ-021 WAIT: s_tready=0; a latency counter SHALL capture net_out into the output register NET_LATENCY cycles after the net_start cycle, or in the net_start cycle itself if NET_LATENCY=0, then go to SEND.
REQ-022 SEND: the output register SHALL be zero-extended to N_OUT_BYTES*8 bits and emitted MSB byte first, one byte per handshake.
REQ-023 SEND: m_tvalid SHALL stay high and m_tdata SHALL stay stable until m_tready; after the last handshake the FSM SHALL go to HUNT with m_tvalid=0 in the next cycle.
REQ-024 Frame-to-frame latency: the next SYNC_BYTE SHALL be accepted no earlier than the cycle after the last output handshake.
REQ-025 s_tready SHALL be 0 in WAIT and SEND; upstream bytes are back-pressured, not dropped.

Reset
REQ-026 On rst_n low the block SHALL asynchronously force state=HUNT and clear all counters, net_in, output register and err_cnt; net_start=0, m_tvalid=0, m_tdata=0.
REQ-027 A reset asserted mid-frame or mid-SEND SHALL abandon the frame without emitting any further byte; err_cnt SHALL NOT count it.

Structure
REQ-028 Package lutnn_frame_pkg SHALL hold the state enum, the SYNC_BYTE default and the TIMEOUT_CYC default.
REQ-029 No sub-module SHALL be used; uart_rx, uart_tx and the network are instantiated beside this block by the board top.

Verification (IN_BITS=12, OUT_BITS=10, NET_LATENCY=2, TIMEOUT_CYC=50 unless stated)
REQ-030 Send A5,0F,3C -> net_in=12'hF3C; one net_start; output 8'h02,8'hC5 when net_out=10'h2C5.
REQ-031 Send 00,11,A5,01,02 -> first two bytes discarded; net_in=12'h102; exactly 2 output bytes.
REQ-032 Send A5,0F then idle 50 cycles -> err_cnt=1; state HUNT; no output; a following A5,01,02 frame completes normally.
REQ-033 With m_tready held low 100 cycles during SEND -> m_tdata stable, s_tready=0 throughout; on release both bytes are delivered in order.
REQ-034 Pull rst_n low after A5,0F -> busy=0 and m_tvalid=0 immediately; a fresh frame is then processed correctly; err_cnt=0.
REQ-035 Run with NET_LATENCY=0 -> net_out is captured in the net_start cycle; 300 back-to-back frames are processed with no loss and err_cnt=0.

Source files
------------

// File: rtl/lutnn_frame_pkg.sv
// Shared types and defaults for the LUT-network UART framing controller.
package lutnn_frame_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         TIMEOUT_CYC_DEF = 120000;

endpackage

// File: rtl/lutnn_frame_ctrl.sv
// Frames UART bytes into a network input vector, fires inference once per frame,
// and streams the zero-extended result back out MSB byte first.
module lutnn_frame_ctrl
  import lutnn_frame_pkg::*;
#(
  parameter int         IN_BITS     = 400,
  parameter int         OUT_BITS    = 4,
  parameter int         NET_LATENCY = 0,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [7:0]          m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [IN_BITS-1:0]  net_in,
  output logic                net_start,
  input  logic [OUT_BITS-1:0] net_out,
  output logic [7:0]          err_cnt,
  output logic                busy
);

  localparam int N_IN_BYTES  = (IN_BITS + 7) / 8;
  localparam int N_OUT_BYTES = (OUT_BITS + 7) / 8;
  localparam int SH_W        = N_IN_BYTES * 8;
  localparam int OB_W        = N_OUT_BYTES * 8;
  localparam int BC_W        = $clog2(N_IN_BYTES + 1);
  localparam int OC_W        = $clog2(N_OUT_BYTES + 1);
  localparam int LC_W        = $clog2(NET_LATENCY + 2);
  localparam int IC_W        = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BC_W-1:0] LAST_IN  = BC_W'(N_IN_BYTES - 1);
  localparam logic [OC_W-1:0] LAST_OUT = OC_W'(N_OUT_BYTES - 1);
  localparam logic [LC_W-1:0] LAT      = LC_W'(NET_LATENCY);
  localparam logic [IC_W-1:0] IDLE_MAX = IC_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [OB_W-1:0]   out_q, out_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [OC_W-1:0]   ocnt_q, ocnt_d;
  logic [LC_W-1:0]   lcnt_q, lcnt_d;
  logic [IC_W-1:0]   idle_q, idle_d;
  logic [7:0]        err_q, err_d;
  logic              start_q, start_d;
  logic              s_hs, m_hs;

  assign s_tready  = (state_q == HUNT) || (state_q == RECV);
  assign m_tvalid  = (state_q == SEND);
  assign m_tdata   = out_q[OB_W-1 -: 8];
  assign net_in    = sh_q[IN_BITS-1:0];
  assign net_start = start_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q != HUNT);

  assign s_hs = s_tvalid & s_tready;
  assign m_hs = m_tvalid & m_tready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    out_d   = out_q;
    bcnt_d  = bcnt_q;
    ocnt_d  = ocnt_q;
    lcnt_d  = lcnt_q;
    idle_d  = idle_q;
    err_d   = err_q;
    start_d = 1'b0;
    case (state_q)
      HUNT: begin
        if (s_hs && (s_tdata == SYNC_BYTE)) begin
          state_d = RECV;
          bcnt_d  = '0;
          idle_d  = '0;
        end
      end
      RECV: begin
        if (s_hs) begin
          // first byte ends up at the MSB end; its top bits are padding
          sh_d   = (sh_q << 8) | SH_W'(s_tdata);
          idle_d = '0;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == LAST_IN) begin
            state_d = WAIT;
            start_d = 1'b1;
            lcnt_d  = '0;
          end
        end else if (idle_q == IDLE_MAX) begin
          state_d = HUNT;
          sh_d    = '0;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      WAIT: begin
        // lcnt is 0 in the net_start cycle, so LAT=0 captures right there
        if (lcnt_q == LAT) begin
          out_d                 = '0;
          out_d[OUT_BITS-1:0]   = net_out;
          ocnt_d                = '0;
          state_d               = SEND;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      SEND: begin
        if (m_hs) begin
          out_d  = out_q << 8;
          ocnt_d = ocnt_q + 1'b1;
          if (ocnt_q == LAST_OUT) state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      sh_q    <= '0;
      out_q   <= '0;
      bcnt_q  <= '0;
      ocnt_q  <= '0;
      lcnt_q  <= '0;
      idle_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      bcnt_q  <= bcnt_d;
      ocnt_q  <= ocnt_d;
      lcnt_q  <= lcnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

endmodule
